// File: rtl/strobe_sched_if.sv
// ============================================================================
// Module   : strobe_sched_if
// Brief    : Config/control and status bundle for the strobe scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface strobe_sched_if #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 4,
    parameter int ACC_W  = 8
);
    localparam int c_ch_w = $clog2(NUM_CH);

    logic                enable;
    logic                cfg_we;
    logic [c_ch_w-1:0]   cfg_ch;
    logic [DIV_W-1:0]    cfg_period;
    logic [ACC_W-1:0]    cfg_step;
    logic                acc_clr;
    logic [ACC_W-1:0]    acc;
    logic [NUM_CH-1:0]   grant;
    logic                grant_vld;
    logic [NUM_CH-1:0]   overrun;
    logic                busy;

    modport master (
        output enable, cfg_we, cfg_ch, cfg_period, cfg_step, acc_clr,
        input  acc, grant, grant_vld, overrun, busy
    );

    modport slave (
        input  enable, cfg_we, cfg_ch, cfg_period, cfg_step, acc_clr,
        output acc, grant, grant_vld, overrun, busy
    );
endinterface

`default_nettype wire

// File: rtl/strobe_sched.sv
// ============================================================================
// Module   : strobe_sched
// Brief    : NUM_CH periodic strobe channels, round-robin arbitrated onto one
//            shared signed accumulator. Optional STROBE_SCHED_SATURATE_EN
//            makes the accumulator add saturate instead of wrap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module strobe_sched #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 4,
    parameter int ACC_W  = 8
) (
    input  wire logic       clk_in,
    input  wire logic       rst_n,
    strobe_sched_if.slave   bus
);
    localparam int              c_ch_w   = $clog2(NUM_CH);
    localparam logic [c_ch_w:0] c_num_ch = (c_ch_w+1)'(NUM_CH);
`ifdef STROBE_SCHED_SATURATE_EN
    localparam logic [ACC_W-1:0] c_acc_max = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] c_acc_min = {1'b1, {(ACC_W-1){1'b0}}};
`endif

    logic [NUM_CH-1:0] w_pending;
    logic [NUM_CH-1:0] w_overrun;
    logic [NUM_CH-1:0] w_strobe;
    logic [NUM_CH-1:0] w_grant_oh;
    logic [NUM_CH-1:0] w_cfg_hit;
    logic [c_ch_w-1:0] w_gidx;
    logic [c_ch_w-1:0] w_ptr_nxt;
    logic [c_ch_w:0]   w_idx;
    logic [c_ch_w:0]   w_ptr_sum;
    logic              w_found;
    logic [ACC_W-1:0]  w_step_and [NUM_CH];
    logic [ACC_W-1:0]  w_step_g;
    logic [ACC_W-1:0]  w_sum;
    logic [ACC_W-1:0]  w_add;

    logic [c_ch_w-1:0] r_ptr;
    logic [ACC_W-1:0]  r_acc;
    logic [NUM_CH-1:0] r_grant;
    logic              r_grant_vld;

    // Out-of-range channel indices decode to no channel at all.
    always_comb begin
        w_cfg_hit = '0;
        if (bus.cfg_we && ({1'b0, bus.cfg_ch} < c_num_ch)) begin
            w_cfg_hit[bus.cfg_ch] = 1'b1;
        end
    end

    // Round-robin search over registered pending, starting at r_ptr.
    always_comb begin
        w_grant_oh = '0;
        w_gidx     = '0;
        w_found    = 1'b0;
        w_idx      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_idx = {1'b0, r_ptr} + (c_ch_w+1)'(i);
            if (w_idx >= c_num_ch) begin
                w_idx = w_idx - c_num_ch;
            end
            if (!w_found && bus.enable && w_pending[w_idx[c_ch_w-1:0]]) begin
                w_found = 1'b1;
                w_gidx  = w_idx[c_ch_w-1:0];
            end
        end
        if (w_found) begin
            w_grant_oh[w_gidx] = 1'b1;
        end
    end

    always_comb begin
        w_ptr_sum = {1'b0, w_gidx} + (c_ch_w+1)'(1);
        if (w_ptr_sum >= c_num_ch) begin
            w_ptr_sum = '0;
        end
        w_ptr_nxt = w_ptr_sum[c_ch_w-1:0];
    end

    always_comb begin
        w_step_g = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_step_g = w_step_g | w_step_and[i];
        end
    end

    // Signed overflow: operands share a sign that the sum does not.
    always_comb begin
        w_sum = r_acc + w_step_g;
        w_add = w_sum;
`ifdef STROBE_SCHED_SATURATE_EN
        if ((r_acc[ACC_W-1] == w_step_g[ACC_W-1]) &&
            (w_sum[ACC_W-1] != r_acc[ACC_W-1])) begin
            w_add = r_acc[ACC_W-1] ? c_acc_min : c_acc_max;
        end
`else
        w_add = w_sum;
`endif
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [DIV_W-1:0] r_period;
        logic [DIV_W-1:0] r_cnt;
        logic [ACC_W-1:0] r_step;
        logic             r_pend;
        logic             r_ovr;

        assign w_strobe[gi]   = bus.enable && (r_period != '0) && (r_cnt == '0);
        assign w_pending[gi]  = r_pend;
        assign w_overrun[gi]  = r_ovr;
        assign w_step_and[gi] = {ACC_W{w_grant_oh[gi]}} & r_step;

        always_ff @(posedge clk_in or negedge rst_n) begin
            if (!rst_n) begin
                r_period <= '0;
                r_cnt    <= '0;
                r_step   <= '0;
                r_pend   <= 1'b0;
                r_ovr    <= 1'b0;
            end else if (w_cfg_hit[gi]) begin
                // A write suppresses this edge's strobe and drops queued work.
                r_period <= bus.cfg_period;
                r_step   <= bus.cfg_step;
                r_cnt    <= (bus.cfg_period == '0) ? '0 : bus.cfg_period - DIV_W'(1);
                r_pend   <= 1'b0;
                r_ovr    <= 1'b0;
            end else begin
                if (bus.enable && (r_period != '0)) begin
                    r_cnt <= (r_cnt == '0) ? r_period - DIV_W'(1) : r_cnt - DIV_W'(1);
                end
                if (w_strobe[gi]) begin
                    if (r_pend && !w_grant_oh[gi]) begin
                        r_ovr <= 1'b1;
                    end
                    r_pend <= 1'b1;
                end else if (w_grant_oh[gi]) begin
                    r_pend <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_acc       <= '0;
            r_grant     <= '0;
            r_grant_vld <= 1'b0;
        end else begin
            if (bus.enable) begin
                r_grant     <= w_grant_oh;
                r_grant_vld <= w_found;
                if (w_found) begin
                    r_ptr <= w_ptr_nxt;
                end
            end else begin
                r_grant     <= '0;
                r_grant_vld <= 1'b0;
            end
            // Clear-then-add when a clear coincides with a grant.
            if (w_found) begin
                r_acc <= bus.acc_clr ? w_step_g : w_add;
            end else if (bus.acc_clr) begin
                r_acc <= '0;
            end
        end
    end

    assign bus.acc       = r_acc;
    assign bus.grant     = r_grant;
    assign bus.grant_vld = r_grant_vld;
    assign bus.overrun   = w_overrun;
    assign bus.busy      = |w_pending;

endmodule

`default_nettype wire
